wb_arbiter: RTL and testbench

- Write-port driver for the integer register file.
- Accepts writeback results from two producers, the ALU and the load unit (MEM), over valid/ready handshakes.
- Buffers each producer in a small FIFO and arbitrates between them.
- Produces one registered write per cycle on WEN/RD_SEL/WB_DATA, which connect directly to the register file's write port.

---
 rtl/wb_arbiter.sv | 152 +++++++++++++++
 tb/tb_wb_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: buffers ALU and load-unit writeback results and drives the register-file write port.
//
// wb_arbiter_fifo ports:
//   CLK, RESET_N          clock, asynchronous active-low reset
//   push, push_rd/data    write one entry (caller guarantees ready)
//   pop                   drop the head entry (caller guarantees not_empty)
//   ready, not_empty      free space present / head valid
//   head_rd, head_data    oldest entry
//
// wb_arbiter ports:
//   CLK, RESET_N                        clock, asynchronous active-low reset
//   ALU_VALID/READY/RD/DATA             ALU result handshake
//   MEM_VALID/READY/RD/DATA             load result handshake
//   WEN, RD_SEL, WB_DATA                registered register-file write port
//   IDLE                                both FIFOs empty and no write in flight
//   RS1_SEL, RS2_SEL, FWDn_HIT/DATA     bypass of the in-flight write (only with WB_FWD_EN defined)

module wb_arbiter_fifo #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          push,
    input  logic [AW-1:0] push_rd,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          ready,
    output logic          not_empty,
    output logic [AW-1:0] head_rd,
    output logic [DW-1:0] head_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] rd_q   [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;

    assign ready     = cnt != CW'(DEPTH);
    assign not_empty = cnt != '0;
    assign head_rd   = rd_q[rp];
    assign head_data = data_q[rp];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            rd_q[wp]   <= push_rd;
            data_q[wp] <= push_data;
        end
    end
endmodule

module wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  ALU_VALID,
    output logic                  ALU_READY,
    input  logic [ADDR_WIDTH-1:0] ALU_RD,
    input  logic [DATA_WIDTH-1:0] ALU_DATA,
    input  logic                  MEM_VALID,
    output logic                  MEM_READY,
    input  logic [ADDR_WIDTH-1:0] MEM_RD,
    input  logic [DATA_WIDTH-1:0] MEM_DATA,
`ifdef WB_FWD_EN
    input  logic [ADDR_WIDTH-1:0] RS1_SEL,
    input  logic [ADDR_WIDTH-1:0] RS2_SEL,
    output logic                  FWD1_HIT,
    output logic                  FWD2_HIT,
    output logic [DATA_WIDTH-1:0] FWD1_DATA,
    output logic [DATA_WIDTH-1:0] FWD2_DATA,
`endif
    output logic                  WEN,
    output logic [ADDR_WIDTH-1:0] RD_SEL,
    output logic [DATA_WIDTH-1:0] WB_DATA,
    output logic                  IDLE
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic                  alu_ne, mem_ne, grant_alu, grant_mem;
    logic [ADDR_WIDTH-1:0] alu_head_rd, mem_head_rd, win_rd;
    logic [DATA_WIDTH-1:0] alu_head_data, mem_head_data, win_data;
    logic [WW-1:0]         wait_cnt;

    wb_arbiter_fifo #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .CLK(CLK), .RESET_N(RESET_N),
        .push(ALU_VALID & ALU_READY), .push_rd(ALU_RD), .push_data(ALU_DATA),
        .pop(grant_alu), .ready(ALU_READY), .not_empty(alu_ne),
        .head_rd(alu_head_rd), .head_data(alu_head_data)
    );

    wb_arbiter_fifo #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .CLK(CLK), .RESET_N(RESET_N),
        .push(MEM_VALID & MEM_READY), .push_rd(MEM_RD), .push_data(MEM_DATA),
        .pop(grant_mem), .ready(MEM_READY), .not_empty(mem_ne),
        .head_rd(mem_head_rd), .head_data(mem_head_data)
    );

    // MEM wins ties unless the ALU head has been passed over MAX_WAIT times.
    always_comb begin
        grant_alu = alu_ne & (~mem_ne | (wait_cnt == WW'(MAX_WAIT)));
        grant_mem = mem_ne & ~grant_alu;
        win_rd    = grant_alu ? alu_head_rd : mem_head_rd;
        win_data  = grant_alu ? alu_head_data : mem_head_data;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            WEN      <= 1'b0;
            RD_SEL   <= '0;
            WB_DATA  <= '0;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= (alu_ne & ~grant_alu)
                      ? ((wait_cnt == WW'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1) : '0;
            // x0 entries still take the slot and update RD_SEL/WB_DATA, but never write.
            WEN <= (grant_alu | grant_mem) & (win_rd != '0);
            if (grant_alu | grant_mem) begin
                RD_SEL  <= win_rd;
                WB_DATA <= win_data;
            end
        end
    end

    assign IDLE = ~alu_ne & ~mem_ne & ~WEN;

`ifdef WB_FWD_EN
    assign FWD1_HIT  = WEN & (RD_SEL == RS1_SEL) & (RS1_SEL != '0);
    assign FWD2_HIT  = WEN & (RD_SEL == RS2_SEL) & (RS2_SEL != '0);
    assign FWD1_DATA = WB_DATA;
    assign FWD2_DATA = WB_DATA;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed bench for wb_arbiter with a queue-based reference model.
module tb_wb_arbiter;
    localparam int AW = 5, DW = 32, DEPTH = 2, MAXW = 4;

    logic          CLK = 1'b0, RESET_N = 1'b0;
    logic          ALU_VALID = 1'b0, MEM_VALID = 1'b0;
    logic [AW-1:0] ALU_RD = '0, MEM_RD = '0;
    logic [DW-1:0] ALU_DATA = '0, MEM_DATA = '0;
    logic          ALU_READY, MEM_READY, WEN, IDLE;
    logic [AW-1:0] RD_SEL;
    logic [DW-1:0] WB_DATA;
`ifdef WB_FWD_EN
    logic [AW-1:0] RS1_SEL = '0, RS2_SEL = '0;
    logic          FWD1_HIT, FWD2_HIT;
    logic [DW-1:0] FWD1_DATA, FWD2_DATA;
`endif

    wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .ALU_VALID(ALU_VALID), .ALU_READY(ALU_READY), .ALU_RD(ALU_RD), .ALU_DATA(ALU_DATA),
        .MEM_VALID(MEM_VALID), .MEM_READY(MEM_READY), .MEM_RD(MEM_RD), .MEM_DATA(MEM_DATA),
`ifdef WB_FWD_EN
        .RS1_SEL(RS1_SEL), .RS2_SEL(RS2_SEL), .FWD1_HIT(FWD1_HIT), .FWD2_HIT(FWD2_HIT),
        .FWD1_DATA(FWD1_DATA), .FWD2_DATA(FWD2_DATA),
`endif
        .WEN(WEN), .RD_SEL(RD_SEL), .WB_DATA(WB_DATA), .IDLE(IDLE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq_a[$], mq_m[$], pend_a[$], pend_m[$];
    logic [AW-1:0] wlog[$];
    int            waited = 0;
    logic          exp_wen = 1'b0;
    logic [AW-1:0] exp_rd = '0;
    logic [DW-1:0] exp_data = '0;
    int            checks = 0, passed = 0;
    bit            run_cmp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: one queue per producer, arbitration applied to whole entries.
    always @(posedge CLK or negedge RESET_N) begin
        bit   ra, rm, ga, gm;
        ent_t w, e;
        if (!RESET_N) begin
            mq_a.delete();
            mq_m.delete();
            waited   = 0;
            exp_wen  = 1'b0;
            exp_rd   = '0;
            exp_data = '0;
        end else begin
            ra = mq_a.size() < DEPTH;
            rm = mq_m.size() < DEPTH;
            ga = mq_a.size() != 0 && (mq_m.size() == 0 || waited == MAXW);
            gm = !ga && mq_m.size() != 0;
            waited  = (mq_a.size() != 0 && !ga) ? ((waited < MAXW) ? waited + 1 : MAXW) : 0;
            exp_wen = 1'b0;
            if (ga || gm) begin
                if (ga) w = mq_a.pop_front();
                else w = mq_m.pop_front();
                exp_rd   = w.rd;
                exp_data = w.data;
                exp_wen  = w.rd != '0;
            end
            if (ALU_VALID && ra) begin
                e.rd = ALU_RD; e.data = ALU_DATA; mq_a.push_back(e);
            end
            if (MEM_VALID && rm) begin
                e.rd = MEM_RD; e.data = MEM_DATA; mq_m.push_back(e);
            end
        end
    end

    always @(negedge CLK) begin
        if (run_cmp) begin
            check("wen", WEN, exp_wen);
            check("rd_sel", RD_SEL, exp_rd);
            check("wb_data", WB_DATA, exp_data);
            check("idle", IDLE, mq_a.size() == 0 && mq_m.size() == 0 && !exp_wen);
            check("alu_ready", ALU_READY, mq_a.size() < DEPTH);
            check("mem_ready", MEM_READY, mq_m.size() < DEPTH);
`ifdef WB_FWD_EN
            check("fwd1_hit", FWD1_HIT, exp_wen && exp_rd == RS1_SEL && RS1_SEL != 0);
            check("fwd2_hit", FWD2_HIT, exp_wen && exp_rd == RS2_SEL && RS2_SEL != 0);
`endif
        end
        if (WEN) wlog.push_back(RD_SEL);
    end

    // Producers present their pending head and hold it until accepted.
    task automatic cycle();
        logic ra, rm;
        ALU_VALID = pend_a.size() != 0;
        MEM_VALID = pend_m.size() != 0;
        if (ALU_VALID) begin ALU_RD = pend_a[0].rd; ALU_DATA = pend_a[0].data; end
        if (MEM_VALID) begin MEM_RD = pend_m[0].rd; MEM_DATA = pend_m[0].data; end
        ra = ALU_READY;
        rm = MEM_READY;
        @(posedge CLK);
        #1;
        if (ALU_VALID && ra) pend_a.delete(0);
        if (MEM_VALID && rm) pend_m.delete(0);
        ALU_VALID = 1'b0;
        MEM_VALID = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((!IDLE || pend_a.size() != 0 || pend_m.size() != 0) && n < 50) begin
            cycle();
            n++;
        end
        check(name, IDLE, 1'b1);
    endtask

    task automatic add_a(input logic [AW-1:0] rd, input logic [DW-1:0] data);
        ent_t e;
        e.rd = rd; e.data = data; pend_a.push_back(e);
    endtask

    task automatic add_m(input logic [AW-1:0] rd, input logic [DW-1:0] data);
        ent_t e;
        e.rd = rd; e.data = data; pend_m.push_back(e);
    endtask

    initial begin
        logic [AW-1:0] alu_order[$];
        repeat (2) @(posedge CLK);
        #1;
        run_cmp = 1'b1;
        check("rst_wen", WEN, 1'b0);
        check("rst_rd_sel", RD_SEL, 0);
        check("rst_wb_data", WB_DATA, 0);
        check("rst_idle", IDLE, 1'b1);
        RESET_N = 1'b1;
        #1;
        check("rst_alu_ready", ALU_READY, 1'b1);
        check("rst_mem_ready", MEM_READY, 1'b1);

        add_a(5, 32'h12345678);
        cycle();
        check("alu_busy", IDLE, 1'b0);
        cycle();
        check("alu_wen", WEN, 1'b1);
        check("alu_rd", RD_SEL, 5);
        check("alu_data", WB_DATA, 32'h12345678);
        cycle();
        check("alu_wen_off", WEN, 1'b0);
        check("alu_idle", IDLE, 1'b1);

        add_m(9, 32'hCAFEBABE);
        cycle();
        cycle();
        check("mem_wen", WEN, 1'b1);
        check("mem_rd", RD_SEL, 9);
        check("mem_data", WB_DATA, 32'hCAFEBABE);
        cycle();

        add_a(1, 32'hA);
        add_m(2, 32'hB);
        cycle();
        cycle();
        check("sim_first_rd", RD_SEL, 2);
        check("sim_first_data", WB_DATA, 32'hB);
        cycle();
        check("sim_second_rd", RD_SEL, 1);
        check("sim_second_data", WB_DATA, 32'hA);
        check("sim_second_wen", WEN, 1'b1);
        cycle();

        add_a(3, 32'h33);
        for (int i = 0; i < 6; i++) add_m(AW'(10 + i), 32'h100 + i);
        repeat (5) cycle();
        check("starve_4th_mem", RD_SEL, 13);
        cycle();
        check("starve_alu_rd", RD_SEL, 3);
        check("starve_alu_data", WB_DATA, 32'h33);
        check("starve_alu_wen", WEN, 1'b1);
        cycle();
        check("starve_after1", RD_SEL, 14);
        cycle();
        check("starve_after2", RD_SEL, 15);
        drain("starve_drain");

        wlog.delete();
        for (int i = 0; i < 8; i++) add_m(AW'(16 + i), 32'h200 + i);
        for (int i = 0; i < 3; i++) add_a(AW'(6 + i), 32'hA0 + i);
        cycle();
        check("bp_ready_1", ALU_READY, 1'b1);
        cycle();
        check("bp_ready_full", ALU_READY, 1'b0);
        drain("bp_drain");
        foreach (wlog[i]) if (wlog[i] >= 6 && wlog[i] <= 8) alu_order.push_back(wlog[i]);
        check("bp_alu_count", alu_order.size(), 3);
        for (int i = 0; i < 3 && i < alu_order.size(); i++)
            check($sformatf("bp_alu_order%0d", i), alu_order[i], 6 + i);

        add_a(0, 32'hFFFFFFFF);
        add_a(4, 32'h44);
        cycle();
        cycle();
        check("x0_wen", WEN, 1'b0);
        check("x0_rd", RD_SEL, 0);
        check("x0_data", WB_DATA, 32'hFFFFFFFF);
        cycle();
        check("x0_next_wen", WEN, 1'b1);
        check("x0_next_rd", RD_SEL, 4);
        cycle();

`ifdef WB_FWD_EN
        RS1_SEL = 7;
        RS2_SEL = 0;
        add_a(7, 32'h77);
        cycle();
        cycle();
        check("fwd1_hit_lit", FWD1_HIT, 1'b1);
        check("fwd1_data_lit", FWD1_DATA, 32'h77);
        check("fwd2_hit_lit", FWD2_HIT, 1'b0);
        cycle();
`endif

        for (int i = 0; i < 3; i++) add_a(AW'(1 + i), 32'h300 + i);
        for (int i = 0; i < 3; i++) add_m(AW'(24 + i), 32'h400 + i);
        cycle();
        cycle();
        check("pre_rst_wen", WEN, 1'b1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("mid_rst_wen", WEN, 1'b0);
        check("mid_rst_idle", IDLE, 1'b1);
        pend_a.delete();
        pend_m.delete();
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check($sformatf("post_rst_wen%0d", i), WEN, 1'b0);
        end
        drain("final_drain");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
